// File: rtl/fixed_pkg.sv
// Shared definitions for the signed fixed-point multiplier: mode encodings and
// the signed range limits used when clamping results.
package fixed_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;
    localparam int SAT_WRAP      = 0;
    localparam int SAT_CLAMP     = 1;

    // Wide enough to hold the limits of any supported operand width.
    localparam int FIXED_CALC_W  = 128;

    function automatic logic signed [FIXED_CALC_W-1:0] fixed_max(input int width);
        fixed_max = (128'sd1 <<< (width - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [FIXED_CALC_W-1:0] fixed_min(input int width);
        fixed_min = -(128'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational post-processing of a full-width signed product: optional
// half-up rounding, arithmetic shift by Q_BITS, range check and clamp/wrap.
module fixed_round_sat
    import fixed_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int Q_BITS   = 16,
    parameter int ROUND    = ROUND_TRUNC,
    parameter int SATURATE = SAT_CLAMP
) (
    input  logic [2*WIDTH-1:0] i_product,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_overflow
);

    localparam int PW     = 2 * WIDTH;
    localparam int RND_SH = (Q_BITS > 0) ? (Q_BITS - 1) : 0;
    // With no fractional bits the rounding increment is zero, so ROUND has no effect.
    localparam logic [PW-1:0] RND_ONE = (Q_BITS > 0) ? (PW'(1'b1) << RND_SH) : '0;

    localparam logic signed [FIXED_CALC_W-1:0] MAX_WIDE = fixed_max(WIDTH);
    localparam logic signed [FIXED_CALC_W-1:0] MIN_WIDE = fixed_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX = MAX_WIDE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN = MIN_WIDE[WIDTH-1:0];

    logic signed [PW-1:0] w_rounded;
    logic signed [PW-1:0] w_shifted;
    logic [PW-WIDTH:0]    w_upper;
    logic                 w_fits;

    // Rounding increment selection.
    always_comb begin
        w_rounded = $signed(i_product);
        case (ROUND)
            ROUND_HALF_UP: w_rounded = $signed(i_product + RND_ONE);
            ROUND_TRUNC:   w_rounded = $signed(i_product);
            default:       w_rounded = $signed(i_product);
        endcase
    end

    // The result fits when every bit from the sign position upward agrees
    // (the product cannot reach 2^(PW-1), so adding the increment never wraps).
    assign w_shifted  = w_rounded >>> Q_BITS;
    assign w_upper    = w_shifted[PW-1:WIDTH-1];
    assign w_fits     = (&w_upper) | (~|w_upper);
    assign o_overflow = ~w_fits;

    // Clamp or wrap the shifted value into WIDTH bits.
    always_comb begin
        o_result = w_shifted[WIDTH-1:0];
        case (SATURATE)
            SAT_CLAMP: begin
                if (w_fits) begin
                    o_result = w_shifted[WIDTH-1:0];
                end else if (w_shifted[PW-1]) begin
                    o_result = SAT_MIN;
                end else begin
                    o_result = SAT_MAX;
                end
            end
            SAT_WRAP: o_result = w_shifted[WIDTH-1:0];
            default:  o_result = w_shifted[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/fixed_mul_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready handshake, full
// backpressure, per-stage valid bits (bubbles collapse) and a sideband tag.
module fixed_mul_pipe
    import fixed_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int Q_BITS   = 16,
    parameter int STAGES   = 2,
    parameter int ROUND    = ROUND_TRUNC,
    parameter int SATURATE = SAT_CLAMP,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW    = 2 * WIDTH;
    localparam int LAST  = STAGES - 1;
    // Stages that carry the raw product; with STAGES > 1 the last stage holds
    // the finished result instead.
    localparam int NPROD = (STAGES > 1) ? (STAGES - 1) : 1;

    logic [STAGES-1:0]    r_valid;
    logic [STAGES-1:0]    w_load;
    logic [PW-1:0]        r_prod [NPROD];
    logic [TAG_W-1:0]     r_tag  [STAGES];
    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic [PW-1:0]        w_product;
    logic [WIDTH-1:0]     w_rs_result;
    logic                 w_rs_overflow;

    assign w_a_ext   = PW'($signed(a));
    assign w_b_ext   = PW'($signed(b));
    assign w_product = w_a_ext * w_b_ext;

    // Load enables ripple back from the output: a stage loads when it is empty
    // or the stage after it is taking its contents.
    always_comb begin
        logic v_take;
        v_take       = !r_valid[LAST] || out_ready;
        w_load       = '0;
        w_load[LAST] = v_take;
        for (int k = LAST - 1; k >= 0; k--) begin
            v_take    = !r_valid[k] || v_take;
            w_load[k] = v_take;
        end
    end

    // Valid chain, product and tag stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < NPROD; k++) begin
                r_prod[k] <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_prod[0] <= w_product;
                    r_tag[0]  <= in_tag;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_tag[k] <= r_tag[k-1];
                    end
                end
            end
            for (int k = 1; k < NPROD; k++) begin
                if (w_load[k] && r_valid[k-1]) begin
                    r_prod[k] <= r_prod[k-1];
                end
            end
        end
    end

    fixed_round_sat #(
        .WIDTH    (WIDTH),
        .Q_BITS   (Q_BITS),
        .ROUND    (ROUND),
        .SATURATE (SATURATE)
    ) u_round_sat (
        .i_product  (r_prod[NPROD-1]),
        .o_result   (w_rs_result),
        .o_overflow (w_rs_overflow)
    );

    if (STAGES > 1) begin : g_out_reg
        logic [WIDTH-1:0] r_result;
        logic             r_overflow;

        // Final stage captures the rounded/clamped value as the op moves in.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_result   <= '0;
                r_overflow <= 1'b0;
            end else if (w_load[LAST] && r_valid[LAST-1]) begin
                r_result   <= w_rs_result;
                r_overflow <= w_rs_overflow;
            end
        end

        assign result   = r_result;
        assign overflow = r_overflow;
    end else begin : g_out_comb
        assign result   = w_rs_result;
        assign overflow = w_rs_overflow;
    end

    assign out_valid = r_valid[LAST];
    assign out_tag   = r_tag[LAST];
    assign in_ready  = w_load[0];

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// Directed and swept checks of fixed_mul_pipe over several depth/round/saturate
// configurations, with a backpressure stream and a mid-stream reset.
module tb_fixed_mul_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Sweep group: 12 instances share inputs; index g -> STAGES {1,2,4}[g/4],
    // ROUND = g%2, SATURATE = (g/2)%2.
    logic        sw_valid;
    logic [31:0] sw_a, sw_b;
    logic [3:0]  sw_tag;
    logic        sw_out_ready;
    logic [11:0] g_in_ready, g_out_valid, g_overflow;
    logic [31:0] g_result  [12];
    logic [3:0]  g_out_tag [12];

    for (genvar g = 0; g < 12; g++) begin : g_dut
        fixed_mul_pipe #(
            .WIDTH(32), .Q_BITS(16),
            .STAGES((g < 4) ? 1 : ((g < 8) ? 2 : 4)),
            .ROUND(g % 2), .SATURATE((g / 2) % 2), .TAG_W(4)
        ) u_dut (
            .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(g_in_ready[g]),
            .a(sw_a), .b(sw_b), .in_tag(sw_tag), .out_valid(g_out_valid[g]),
            .out_ready(sw_out_ready), .result(g_result[g]),
            .overflow(g_overflow[g]), .out_tag(g_out_tag[g])
        );
    end

    // Backpressure instance, STAGES=3, truncate, saturate.
    logic        bp_valid, bp_in_ready, bp_out_valid, bp_out_ready, bp_overflow;
    logic [31:0] bp_a, bp_b, bp_result;
    logic [3:0]  bp_tag, bp_out_tag;

    fixed_mul_pipe #(
        .WIDTH(32), .Q_BITS(16), .STAGES(3), .ROUND(0), .SATURATE(1), .TAG_W(4)
    ) u_bp (
        .clk(clk), .rst(rst), .in_valid(bp_valid), .in_ready(bp_in_ready),
        .a(bp_a), .b(bp_b), .in_tag(bp_tag), .out_valid(bp_out_valid),
        .out_ready(bp_out_ready), .result(bp_result),
        .overflow(bp_overflow), .out_tag(bp_out_tag)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int sent, recv, occ, full_seen;
    logic stalled_prev;
    logic [32:0] sw_exp [4][1024];
    logic        sw_v   [1024];
    logic [3:0]  sw_th  [1024];

    task automatic chk_bit(input string name, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", name, obs, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", name, obs, exp);
        end
    endtask

    // Reference: wide integer arithmetic straight from the Q-format definition.
    function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input int rnd, input int sat);
        longint p, s;
        logic ov;
        logic [31:0] r;
        p = longint'($signed(ma)) * longint'($signed(mb));
        if (rnd != 0) p = p + 64'sd32768;
        s  = p >>> 16;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        if (ov && sat != 0) r = (s < 0) ? 32'h80000000 : 32'h7FFFFFFF;
        else                r = s[31:0];
        return {ov, r};
    endfunction

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic [3:0] tt);
        sw_a = ta; sw_b = tb_v; sw_tag = tt; sw_valid = 1'b1;
        @(negedge clk);
        sw_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_tag = '0; sw_out_ready = 1'b1;
        bp_valid = 1'b0; bp_a = '0; bp_b = '0; bp_tag = '0; bp_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk_bit ("rst_valid_s2", g_out_valid[6], 1'b0);
        chk_word("rst_result_s2", g_result[6], 32'h0);
        chk_bit ("rst_ovf_s2", g_overflow[6], 1'b0);
        chk_word("rst_tag_s2", {28'd0, g_out_tag[6]}, 32'h0);
        chk_word("rst_result_s1r", g_result[3], 32'h0);
        chk_bit ("rst_in_ready", &g_in_ready, 1'b1);
        chk_bit ("rst_bp_valid", bp_out_valid, 1'b0);
        chk_bit ("rst_bp_in_ready", bp_in_ready, 1'b1);

        // 1.5 * 2.0 with exact latency per depth
        send(32'h00018000, 32'h00020000, 4'd5);
        chk_bit ("lat_s1_valid", g_out_valid[2], 1'b1);
        chk_word("lat_s1_result", g_result[2], 32'h00030000);
        chk_bit ("lat_s2_early", g_out_valid[6], 1'b0);
        @(negedge clk);
        chk_bit ("lat_s2_valid", g_out_valid[6], 1'b1);
        chk_word("pos_result", g_result[6], 32'h00030000);
        chk_bit ("pos_ovf", g_overflow[6], 1'b0);
        chk_word("pos_tag", {28'd0, g_out_tag[6]}, 32'd5);
        chk_bit ("lat_s4_early", g_out_valid[10], 1'b0);
        repeat (2) @(negedge clk);
        chk_bit ("lat_s4_valid", g_out_valid[10], 1'b1);
        chk_word("lat_s4_result", g_result[10], 32'h00030000);
        repeat (2) @(negedge clk);

        // -1.5 * 2.0
        send(32'hFFFE8000, 32'h00020000, 4'd6);
        @(negedge clk);
        chk_word("neg_result", g_result[6], 32'hFFFD0000);
        chk_bit ("neg_ovf", g_overflow[6], 1'b0);
        repeat (3) @(negedge clk);

        // Rounding of exactly one half LSB
        send(32'h00000001, 32'h00008000, 4'd7);
        @(negedge clk);
        chk_word("rnd_trunc", g_result[6], 32'h00000000);
        chk_word("rnd_halfup", g_result[7], 32'h00000001);
        repeat (3) @(negedge clk);
        send(32'hFFFFFFFF, 32'h00008000, 4'd8);
        @(negedge clk);
        chk_word("rnd_neg_trunc", g_result[6], 32'hFFFFFFFF);
        chk_word("rnd_neg_halfup", g_result[7], 32'h00000000);
        repeat (3) @(negedge clk);

        // Overflow: saturate vs wrap
        send(32'h7FFF0000, 32'h00020000, 4'd9);
        @(negedge clk);
        chk_word("ovf_sat_result", g_result[6], 32'h7FFFFFFF);
        chk_bit ("ovf_sat_flag", g_overflow[6], 1'b1);
        chk_word("ovf_wrap_result", g_result[4], 32'hFFFE0000);
        chk_bit ("ovf_wrap_flag", g_overflow[4], 1'b1);
        repeat (3) @(negedge clk);
        send(32'h80000000, 32'h80000000, 4'd10);
        @(negedge clk);
        chk_word("minmin_sat", g_result[6], 32'h7FFFFFFF);
        chk_bit ("minmin_ovf", g_overflow[6], 1'b1);
        chk_word("minmin_wrap", g_result[4], 32'h00000000);
        repeat (4) @(negedge clk);

        // Backpressure stream of 10 ops on the 3-stage pipe
        sent = 0; recv = 0; full_seen = 0; stalled_prev = 1'b0;
        for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
            bp_out_ready = (cyc < 6 || (cyc >= 12 && cyc < 18)) ? 1'b0 : 1'($urandom_range(0, 1));
            if (sent < 10) begin
                bp_valid = 1'b1;
                bp_a     = 32'(sent + 1) << 16;
                bp_b     = 32'h00018000;
                bp_tag   = 4'(sent);
            end else begin
                bp_valid = 1'b0;
            end
            #1;
            occ = sent - recv;
            chk_bit("bp_in_ready", bp_in_ready, (occ < 3) || bp_out_ready);
            if (occ == 3 && !bp_out_ready) full_seen++;
            if (stalled_prev) chk_bit("bp_hold_valid", bp_out_valid, 1'b1);
            if (bp_out_valid) begin
                chk_word("bp_tag", {28'd0, bp_out_tag}, 32'(recv));
                chk_word("bp_result", bp_result, 32'((recv + 1) * 32'h00018000));
                chk_bit ("bp_ovf", bp_overflow, 1'b0);
                if (bp_out_ready) recv++;
            end
            stalled_prev = bp_out_valid && !bp_out_ready;
            if (bp_valid && bp_in_ready) sent++;
            @(negedge clk);
        end
        bp_valid = 1'b0;
        bp_out_ready = 1'b0;
        chk_word("bp_recv_count", 32'(recv), 32'd10);
        chk_bit ("bp_full_seen", full_seen > 0, 1'b1);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            bp_valid = 1'b1; bp_a = 32'h00010000; bp_b = 32'h00010000; bp_tag = 4'(12 + i);
            @(negedge clk);
        end
        bp_valid = 1'b0;
        chk_bit("mid_full_valid", bp_out_valid, 1'b1);
        chk_bit("mid_full_in_ready", bp_in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_bit ("mid_rst_valid", bp_out_valid, 1'b0);
        chk_word("mid_rst_result", bp_result, 32'h0);
        chk_bit ("mid_rst_ovf", bp_overflow, 1'b0);
        chk_word("mid_rst_tag", {28'd0, bp_out_tag}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        bp_out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk_bit("mid_no_stale", bp_out_valid, 1'b0);
        end
        bp_valid = 1'b1; bp_a = 32'h00030000; bp_b = 32'hFFFF0000; bp_tag = 4'd9;
        @(negedge clk);
        bp_valid = 1'b0;
        chk_bit("post_rst_lat1", bp_out_valid, 1'b0);
        @(negedge clk);
        chk_bit("post_rst_lat2", bp_out_valid, 1'b0);
        @(negedge clk);
        chk_bit ("post_rst_valid", bp_out_valid, 1'b1);
        chk_word("post_rst_result", bp_result, 32'hFFFD0000);
        chk_word("post_rst_tag", {28'd0, bp_out_tag}, 32'd9);
        repeat (2) @(negedge clk);

        // Random sweep: STAGES 1/2/4 in all ROUND/SATURATE combinations
        for (int t = 0; t < 1004; t++) begin
            for (int g = 0; g < 12; g++) begin
                int st, idx, c;
                st  = (g < 4) ? 1 : ((g < 8) ? 2 : 4);
                idx = t - st;
                c   = g % 4;
                if (idx >= 0) begin
                    chk_bit("sw_valid", g_out_valid[g], sw_v[idx]);
                    if (sw_v[idx]) begin
                        chk_word("sw_result", g_result[g], sw_exp[c][idx][31:0]);
                        chk_bit ("sw_ovf", g_overflow[g], sw_exp[c][idx][32]);
                        chk_word("sw_tag", {28'd0, g_out_tag[g]}, {28'd0, sw_th[idx]});
                    end
                end else begin
                    chk_bit("sw_valid_idle", g_out_valid[g], 1'b0);
                end
            end
            chk_bit("sw_in_ready", &g_in_ready, 1'b1);
            if (t < 1000) begin
                int sel;
                sw_a = $urandom;
                sw_b = $urandom;
                sel = $urandom_range(0, 7);
                if (sel < 4)       sw_a = {{12{sw_a[19]}}, sw_a[19:0]};
                else if (sel == 4) sw_a = 32'h80000000;
                else if (sel == 5) sw_a = 32'h7FFFFFFF;
                sel = $urandom_range(0, 7);
                if (sel < 5)       sw_b = {{12{sw_b[19]}}, sw_b[19:0]};
                else if (sel == 5) sw_b = 32'h80000000;
                sw_tag   = 4'(t);
                sw_valid = ($urandom_range(0, 3) != 0);
                sw_v[t]  = sw_valid;
                sw_th[t] = sw_tag;
                for (int c = 0; c < 4; c++) begin
                    sw_exp[c][t] = model(sw_a, sw_b, c % 2, c / 2);
                end
            end else begin
                sw_valid = 1'b0;
                sw_v[t]  = 1'b0;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
